vend_sequencer: RTL

//  Controller in front of piggyBank. Arbitrates the four item buttons, checks credit,

---
 rtl/vend_sequencer_if.sv | 36 +++
 rtl/vend_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer_if.sv
// Bus between the vending sequencer and its neighbours: coin slot and
// buttons in, credit from piggyBank in, add/debit pulses and status out.
// The sequencer connects through the slave modport; the environment
// (slot, buttons, bank) uses the master modport.
interface vend_sequencer_if;
    logic [3:0] coin_in;      // {quarter,dime,nickel,penny}
    logic [3:0] item_req;     // {date,carrot,banana,apple}
    logic [7:0] credit;
    logic       penny;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic       apple;
    logic       banana;
    logic       carrot;
    logic       date;
    logic       coin_reject;
    logic       dispense_o;
    logic       deny_o;
    logic [1:0] grant_o;
    logic       busy_o;

    modport slave (
        input  coin_in, item_req, credit,
        output penny, nickel, dime, quarter,
        output apple, banana, carrot, date,
        output coin_reject, dispense_o, deny_o, grant_o, busy_o
    );

    modport master (
        output coin_in, item_req, credit,
        input  penny, nickel, dime, quarter,
        input  apple, banana, carrot, date,
        input  coin_reject, dispense_o, deny_o, grant_o, busy_o
    );
endinterface

// File: rtl/vend_sequencer.sv
// vend_sequencer: controller in front of piggyBank.
// Latches item buttons, arbitrates them, checks credit, issues one debit
// pulse per successful purchase and times the dispense output. Coins are
// queued (one pending bit per denomination) and forwarded one per cycle,
// rejecting any coin that would push credit past 255.
// All bank pulses are registered, so the bank's credit reflects a pulse
// two cycles after the forwarding decision; the coin that is "in flight"
// (decided last cycle) is therefore added into the overflow check, and the
// credit check waits until nothing is in flight.
// Optional feature: define RR_ARB_EN for round-robin arbitration;
// otherwise fixed priority apple > banana > carrot > date.
module vend_sequencer #(
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned PRICE_A         = 75,
    parameter int unsigned PRICE_B         = 20,
    parameter int unsigned PRICE_C         = 30,
    parameter int unsigned PRICE_D         = 40
) (
    input  logic             clk,
    input  logic             reset,    // asynchronous, active-low
    vend_sequencer_if.slave  bus_if
);

    localparam int unsigned CNT_W = $clog2(DISPENSE_CYCLES + 1);
    localparam logic [7:0]  P_A   = 8'(PRICE_A);
    localparam logic [7:0]  P_B   = 8'(PRICE_B);
    localparam logic [7:0]  P_C   = 8'(PRICE_C);
    localparam logic [7:0]  P_D   = 8'(PRICE_D);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DEBIT,
        S_DISPENSE,
        S_DENY
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         req_q, req_d;
    logic [3:0]         req_clr;
    logic [3:0]         pend_q, pend_d;
    logic [3:0]         coin_q, coin_d;
    logic               rej_q, rej_d;
    logic [1:0]         arb_idx;
    logic               in_flight;

    logic [1:0]         sel_idx;
    logic               sel_any;
    logic [3:0]         coin_clr;
    logic [3:0]         coin_dup;
    logic               coin_ovf;
    logic [8:0]         coin_sum;

    // Value in cents of coin slot index {penny,nickel,dime,quarter}.
    function automatic logic [5:0] coin_value(input logic [1:0] idx);
        case (idx)
            2'd0:    coin_value = 6'd1;
            2'd1:    coin_value = 6'd5;
            2'd2:    coin_value = 6'd10;
            default: coin_value = 6'd25;
        endcase
    endfunction

    // Value of a registered (one-hot or empty) coin pulse vector.
    function automatic logic [5:0] pulse_value(input logic [3:0] p);
        pulse_value = 6'd0;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) pulse_value = pulse_value + coin_value(2'(i));
        end
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = P_A;
            2'd1:    price_of = P_B;
            2'd2:    price_of = P_C;
            default: price_of = P_D;
        endcase
    endfunction

    // A coin decided last cycle is on the bus now; the bank has not counted it yet.
    assign in_flight = |coin_q;

`ifdef RR_ARB_EN
    logic [1:0] rr_q, rr_d;

    // Round-robin pick: first latched request at or after the pointer.
    always_comb begin
        arb_idx = rr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req_q[rr_q + 2'(k)]) arb_idx = rr_q + 2'(k);
        end
    end

    // Pointer moves past every grant, whether it ends served or denied.
    always_comb begin
        rr_d = rr_q;
        if (state_q == S_IDLE && (|req_q)) rr_d = arb_idx + 2'd1;
    end

    // Round-robin pointer register; starts at apple.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_q <= 2'd0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed priority pick: lowest index (apple) wins.
    always_comb begin
        arb_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_q[k]) arb_idx = 2'(k);
        end
    end
`endif

    // Purchase FSM next state, grant capture and request-latch clearing.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        req_clr = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (|req_q) begin
                    state_d = S_CHECK;
                    grant_d = arb_idx;
                    req_clr = 4'b0001 << arb_idx;
                end
            end
            S_CHECK: begin
                // Credit is only trusted once no coin pulse is pending in the bank.
                if (!in_flight) begin
                    if (bus_if.credit >= price_of(grant_q)) state_d = S_DEBIT;
                    else                                    state_d = S_DENY;
                end
            end
            S_DEBIT: begin
                state_d = S_DISPENSE;
                cnt_d   = CNT_W'(DISPENSE_CYCLES - 1);
            end
            S_DISPENSE: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DENY: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (req_q & ~req_clr) | bus_if.item_req;
    end

    // Coin queue: forward the cheapest pending coin unless its pulse would
    // land in the debit cycle; reject on overflow or duplicate arrival.
    always_comb begin
        sel_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[k]) sel_idx = 2'(k);
        end
        sel_any  = |pend_q;
        coin_sum = {1'b0, bus_if.credit} + 9'(coin_value(sel_idx)) + 9'(pulse_value(coin_q));
        coin_clr = 4'b0000;
        coin_d   = 4'b0000;
        coin_ovf = 1'b0;
        if (sel_any && (state_d != S_DEBIT)) begin
            coin_clr[sel_idx] = 1'b1;
            if (coin_sum > 9'd255) coin_ovf = 1'b1;
            else                   coin_d[sel_idx] = 1'b1;
        end
        coin_dup = bus_if.coin_in & pend_q & ~coin_clr;
        rej_d    = coin_ovf | (|coin_dup);
        pend_d   = (pend_q & ~coin_clr) | bus_if.coin_in;
    end

    // State, latches and registered bank pulses; reset aborts any purchase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= 2'd0;
            cnt_q   <= '0;
            req_q   <= 4'b0000;
            pend_q  <= 4'b0000;
            coin_q  <= 4'b0000;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            coin_q  <= coin_d;
            rej_q   <= rej_d;
        end
    end

    assign bus_if.penny       = coin_q[0];
    assign bus_if.nickel      = coin_q[1];
    assign bus_if.dime        = coin_q[2];
    assign bus_if.quarter     = coin_q[3];
    assign bus_if.coin_reject = rej_q;

    assign bus_if.apple       = (state_q == S_DEBIT) && (grant_q == 2'd0);
    assign bus_if.banana      = (state_q == S_DEBIT) && (grant_q == 2'd1);
    assign bus_if.carrot      = (state_q == S_DEBIT) && (grant_q == 2'd2);
    assign bus_if.date        = (state_q == S_DEBIT) && (grant_q == 2'd3);

    assign bus_if.dispense_o  = (state_q == S_DISPENSE);
    assign bus_if.deny_o      = (state_q == S_DENY);
    assign bus_if.busy_o      = (state_q != S_IDLE);
    assign bus_if.grant_o     = (state_q != S_IDLE) ? grant_q : 2'd0;

endmodule
